// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction-fetch slice.
//   fetch_entry_t : {pc, instr, fault} record carried from fetch to decode
//   NOP_INSTR     : instruction word placed in fault markers (addi x0,x0,0)
//   fetch_state_e : fetch FSM states
//   pc_legal()    : aligned and inside the memory image
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  // Word fetch is legal only when the full 4-byte word lies inside memory.
  function automatic logic pc_legal(input logic [31:0] pc, input logic [31:0] mem_bytes);
    return (pc[1:0] == 2'b00) && (pc <= mem_bytes - 32'd4);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry FIFO of fetch_entry_t.
//   clk, rst_n : clock, async active-low reset
//   push, din  : enqueue request and data (ignored when full unless popping)
//   pop        : dequeue head (ignored when empty)
//   flush      : empty the FIFO; wins over push and pop
//   head       : current head entry, all-zero when empty
//   valid      : head holds an entry
//   count      : number of entries held (0..2)
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         valid,
  output logic [1:0]   count
);

  // ent[0] is always the head; a pop shifts ent[1] down so the head is read
  // without a pointer mux.
  fetch_entry_t [1:0] ent;
  logic [1:0]         cnt;
  logic               do_pop;
  logic               do_push;

  always_comb begin
    do_pop  = pop & (cnt != 2'd0);
    do_push = push & ((cnt != 2'd2) | do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 2'd0;
      ent <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
      ent <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          ent[cnt[0]] <= din;
          cnt         <= cnt + 2'd1;
        end
        2'b01: begin
          ent[0] <= ent[1];
          ent[1] <= '0;
          cnt    <= cnt - 2'd1;
        end
        2'b11: begin
          // Count unchanged; the new entry lands behind whatever survives.
          if (cnt == 2'd1) begin
            ent[0] <= din;
          end else begin
            ent[0] <= ent[1];
            ent[1] <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (cnt != 2'd0);
  assign head  = valid ? ent[0] : '0;
  assign count = cnt;

endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch controller.
//   Owns the pc, drives imem_addr = pc, captures {pc, instr, fault} into a
//   2-entry buffer presented to decode over valid/ready. Redirects flush the
//   buffer and reload pc; illegal fetches emit one fault marker and park the
//   FSM in FAULT until the next redirect.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   fetch_en         : fetch permitted this cycle
//   imem_addr        : byte address to imem (current pc)
//   imem_rdata       : instruction word, same-cycle read
//   redirect_valid   : redirect request (highest priority)
//   redirect_pc      : redirect target
//   out_valid/ready  : head handshake to decode
//   out_pc/instr/fault : head contents, zero when empty
module ifetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault
);

  localparam logic [31:0] MEM_BYTES = 32'(IMEM_BYTES);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic         legal;
  logic         pop, can_enq;
  logic         push, flush, fifo_pop;
  fetch_entry_t push_entry;
  fetch_entry_t head;
  logic         head_vld;
  logic [1:0]   count;

  assign legal     = pc_legal(pc, MEM_BYTES);
  assign pop       = head_vld & out_ready;
  assign can_enq   = (count != 2'd2) | pop;
  assign imem_addr = pc;

  // State / pc register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Next-state
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = RUN;
    end else if (state == RUN && fetch_en && can_enq && !legal) begin
      state_nxt = FAULT;
    end
  end

  // Outputs: buffer control and pc update
  always_comb begin
    push       = 1'b0;
    flush      = 1'b0;
    fifo_pop   = 1'b0;
    pc_nxt     = pc;
    push_entry = '0;
    if (redirect_valid) begin
      // Drops the buffer including any same-cycle pop; nothing enqueued.
      flush  = 1'b1;
      pc_nxt = redirect_pc;
    end else begin
      fifo_pop = pop;
      if (state == RUN && fetch_en && can_enq) begin
        push = 1'b1;
        if (legal) begin
          push_entry = '{pc: pc, instr: imem_rdata, fault: 1'b0};
          pc_nxt     = pc + 32'd4;
        end else begin
          // pc holds on the faulting address so it is visible in imem_addr.
          push_entry = '{pc: pc, instr: NOP_INSTR, fault: 1'b1};
        end
      end
    end
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_entry),
    .pop   (fifo_pop),
    .flush (flush),
    .head  (head),
    .valid (head_vld),
    .count (count)
  );

  assign out_valid = head_vld;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign out_fault = head.fault;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed bench with a scoreboard. Stimulus pushes the
// expected accepted entries; a negedge monitor pops and compares each
// accepted head and checks head stability under backpressure.
module tb_ifetch_ctrl;
  import fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;

  fetch_entry_t exp_q[$];
  logic [31:0]  mem [256];

  ifetch_ctrl #(.RESET_PC(32'h0), .IMEM_BYTES(1024)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_fault      (out_fault)
  );

  assign imem_rdata = mem[imem_addr[9:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_ok(input logic [31:0] pc);
    exp_q.push_back('{pc: pc, instr: mem[pc[9:2]], fault: 1'b0});
  endtask

  task automatic exp_flt(input logic [31:0] pc);
    exp_q.push_back('{pc: pc, instr: 32'h0000_0013, fault: 1'b1});
  endtask

  // Monitor: accepted heads against the scoreboard, head stability on stall.
  initial begin
    fetch_entry_t e;
    fetch_entry_t prev;
    logic stall;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_hold_pc", out_pc, prev.pc);
          chk("stall_hold_instr", out_instr, prev.instr);
        end
        if (out_valid && out_ready && !redirect_valid) begin
          acc_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_accept: got pc=%h instr=%h fault=%b expected none",
                     out_pc, out_instr, out_fault);
          end else begin
            e = exp_q.pop_front();
            if (out_pc !== e.pc || out_instr !== e.instr || out_fault !== e.fault) begin
              failures++;
              $display("FAIL accept_%0d: got pc=%h instr=%h fault=%b expected pc=%h instr=%h fault=%b",
                       acc_cnt, out_pc, out_instr, out_fault, e.pc, e.instr, e.fault);
            end
          end
        end
        stall = out_valid && !out_ready && !redirect_valid;
        prev  = '{pc: out_pc, instr: out_instr, fault: out_fault};
      end
    end
  end

  initial begin
    int a0;
    for (int i = 0; i < 256; i++) mem[i] = {16'hA5A5, 16'(i)};
    mem[0] = 32'h00f00093;
    mem[1] = 32'h01600113;

    rst_n = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_fault", {31'd0, out_fault}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);

    // A: streaming after reset release
    cyc(); cyc();
    fetch_en = 1'b1; out_ready = 1'b1; rst_n = 1'b1;
    for (int i = 0; i < 6; i++) exp_ok(32'(i * 4));
    a0 = acc_cnt;
    cyc();
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("first_pc", out_pc, 32'h0);
    chk("first_instr", out_instr, 32'h00f00093);
    repeat (5) cyc();
    fetch_en = 1'b0;
    cyc();
    chk("stream_accepts", 32'(acc_cnt - a0), 32'd6);
    chk("stream_q_empty", 32'(exp_q.size()), 32'd0);

    // B: backpressure
    rst_n = 1'b0; cyc(); cyc();
    out_ready = 1'b0; fetch_en = 1'b1; rst_n = 1'b1;
    repeat (5) cyc();
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_head_pc", out_pc, 32'h0);
    chk("bp_imem_addr", imem_addr, 32'h8);
    exp_ok(32'h0); exp_ok(32'h4); exp_ok(32'h8);
    out_ready = 1'b1;
    cyc();
    fetch_en = 1'b0;
    cyc(); cyc();
    chk("bp_drain_empty", {31'd0, out_valid}, 32'd0);
    chk("bp_imem_addr_after", imem_addr, 32'hC);
    chk("bp_q_empty", 32'(exp_q.size()), 32'd0);

    // C: redirect while holding pc 8 and 12
    rst_n = 1'b0; cyc(); cyc();
    out_ready = 1'b1; fetch_en = 1'b1; rst_n = 1'b1;
    exp_ok(32'h0); exp_ok(32'h4);
    repeat (3) cyc();
    out_ready = 1'b0;
    repeat (2) cyc();
    chk("rd_head_pc", out_pc, 32'h8);
    redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
    cyc();
    chk("rd_bubble_valid", {31'd0, out_valid}, 32'd0);
    chk("rd_imem_addr", imem_addr, 32'h40);
    redirect_valid = 1'b0;
    exp_ok(32'h40);
    cyc();
    chk("rd_target_valid", {31'd0, out_valid}, 32'd1);
    chk("rd_target_pc", out_pc, 32'h40);
    fetch_en = 1'b0;
    cyc();
    chk("rd_q_empty", 32'(exp_q.size()), 32'd0);

    // D: misaligned redirect, then recovery
    redirect_valid = 1'b1; redirect_pc = 32'h22; fetch_en = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    exp_flt(32'h22);
    cyc();
    chk("mis_fault", {31'd0, out_fault}, 32'd1);
    chk("mis_pc", out_pc, 32'h22);
    chk("mis_instr", out_instr, NOP_INSTR);
    repeat (4) cyc();
    chk("mis_parked_valid", {31'd0, out_valid}, 32'd0);
    chk("mis_parked_addr", imem_addr, 32'h22);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    cyc();
    redirect_valid = 1'b0;
    exp_ok(32'h10);
    cyc();
    chk("mis_resume_pc", out_pc, 32'h10);
    chk("mis_resume_fault", {31'd0, out_fault}, 32'd0);
    fetch_en = 1'b0;
    cyc();

    // E: run off the end of memory
    redirect_valid = 1'b1; redirect_pc = 32'h3F0; fetch_en = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    exp_ok(32'h3F0); exp_ok(32'h3F4); exp_ok(32'h3F8); exp_ok(32'h3FC);
    exp_flt(32'h400);
    repeat (5) cyc();
    chk("end_fault", {31'd0, out_fault}, 32'd1);
    chk("end_pc", out_pc, 32'h400);
    repeat (3) cyc();
    chk("end_parked_valid", {31'd0, out_valid}, 32'd0);
    chk("end_parked_addr", imem_addr, 32'h400);
    chk("end_q_empty", 32'(exp_q.size()), 32'd0);

    // F: async reset with a full buffer
    redirect_valid = 1'b1; redirect_pc = 32'h20; out_ready = 1'b0;
    cyc();
    redirect_valid = 1'b0;
    repeat (2) cyc();
    chk("ar_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("ar_pre_pc", out_pc, 32'h20);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_pc", out_pc, 32'h0);
    chk("ar_imem_addr", imem_addr, 32'h0);
    cyc(); cyc();
    fetch_en = 1'b1; out_ready = 1'b1; rst_n = 1'b1;
    exp_ok(32'h0);
    cyc();
    chk("ar_restart_pc", out_pc, 32'h0);
    fetch_en = 1'b0;
    cyc();
    cyc();
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
